// File: rtl/bus_interconnect_pkg.sv
// Shared helpers for the bus interconnect: index-width sizing used by the top
// module and the address decoder.
package bus_interconnect_pkg;

   // Index registers never collapse to zero width, even with a single port.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational base/mask address decoder: reports whether any device claims the
// address and, if several do, the lowest-index claimant.
module bus_addr_decode
   import bus_interconnect_pkg::*;
#(
   parameter int NrDevices    = 1,
   parameter int AddressWidth = 32,
   parameter int DevIdxW      = clog2_min1(NrDevices)
) (
   input  logic [AddressWidth-1:0]                addr,
   input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_base,
   input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_mask,
   output logic [DevIdxW-1:0]                     dev_idx,
   output logic                                   match
);

   logic [NrDevices-1:0] hit;

   for (genvar gi = 0; gi < NrDevices; gi++) begin : g_hit
      assign hit[gi] = ((addr & cfg_mask[gi]) == cfg_base[gi]);
   end

   // Scan from the top down so the lowest matching index is the last to land.
   always_comb begin
      dev_idx = '0;
      match   = 1'b0;
      for (int i = NrDevices - 1; i >= 0; i--) begin
         if (hit[i]) begin
            dev_idx = DevIdxW'(i);
            match   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_interconnect.sv
// Single-cycle multi-host to multi-device interconnect: fixed-priority arbitration,
// base/mask decode and a one-deep response tracker routing replies back to hosts.
module bus_interconnect
   import bus_interconnect_pkg::*;
#(
   parameter int NrDevices    = 1,
   parameter int NrHosts      = 1,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [NrHosts-1:0]                      host_req_i,
   output logic [NrHosts-1:0]                      host_gnt_o,
   input  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i,
   input  logic [NrHosts-1:0]                      host_we_i,
   input  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i,
   input  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i,
   output logic [NrHosts-1:0]                      host_rvalid_o,
   output logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o,
   output logic [NrHosts-1:0]                      host_err_o,
   output logic [NrDevices-1:0]                    device_req_o,
   output logic [NrDevices-1:0][AddressWidth-1:0]  device_addr_o,
   output logic [NrDevices-1:0]                    device_we_o,
   output logic [NrDevices-1:0][DataWidth/8-1:0]   device_be_o,
   output logic [NrDevices-1:0][DataWidth-1:0]     device_wdata_o,
   input  logic [NrDevices-1:0]                    device_rvalid_i,
   input  logic [NrDevices-1:0][DataWidth-1:0]     device_rdata_i,
   input  logic [NrDevices-1:0]                    device_err_i,
   input  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_base,
   input  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_mask
);

   localparam int HostIdxW = clog2_min1(NrHosts);
   localparam int DevIdxW  = clog2_min1(NrDevices);

   logic                    win_found;
   logic [HostIdxW-1:0]     win_idx;
   logic [NrHosts-1:0]      win_oh;
   logic [AddressWidth-1:0] win_addr;
   logic                    win_we;
   logic [DataWidth/8-1:0]  win_be;
   logic [DataWidth-1:0]    win_wdata;
   logic [DevIdxW-1:0]      dec_idx;
   logic                    dec_match;

   logic                    valid_reg,    valid_next;
   logic [HostIdxW-1:0]     host_idx_reg, host_idx_next;
   logic [DevIdxW-1:0]      dev_idx_reg,  dev_idx_next;
   logic                    unmapped_reg, unmapped_next;

   logic                    sel_rvalid;
   logic [DataWidth-1:0]    sel_rdata;
   logic                    sel_err;

   // Lowest-index requester wins; its fields are gathered with a one-hot AND-OR.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_oh    = '0;
      win_addr  = '0;
      win_we    = 1'b0;
      win_be    = '0;
      win_wdata = '0;
      for (int i = 0; i < NrHosts; i++) begin
         if (host_req_i[i] && !win_found) begin
            win_found = 1'b1;
            win_idx   = HostIdxW'(i);
            win_oh[i] = 1'b1;
            win_addr  = host_addr_i[i];
            win_we    = host_we_i[i];
            win_be    = host_be_i[i];
            win_wdata = host_wdata_i[i];
         end
      end
   end

   assign host_gnt_o = win_oh;

   bus_addr_decode #(
      .NrDevices    (NrDevices),
      .AddressWidth (AddressWidth),
      .DevIdxW      (DevIdxW)
   ) u_decode (
      .addr     (win_addr),
      .cfg_base (cfg_device_addr_base),
      .cfg_mask (cfg_device_addr_mask),
      .dev_idx  (dec_idx),
      .match    (dec_match)
   );

   for (genvar gi = 0; gi < NrDevices; gi++) begin : g_dev
      logic dev_sel;
      assign dev_sel            = win_found && dec_match && (dec_idx == DevIdxW'(gi));
      assign device_req_o[gi]   = dev_sel;
      assign device_addr_o[gi]  = dev_sel ? win_addr  : '0;
      assign device_we_o[gi]    = dev_sel && win_we;
      assign device_be_o[gi]    = dev_sel ? win_be    : '0;
      assign device_wdata_o[gi] = dev_sel ? win_wdata : '0;
   end

   assign valid_next    = win_found;
   assign host_idx_next = win_idx;
   assign dev_idx_next  = dec_idx;
   assign unmapped_next = win_found && !dec_match;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_reg    <= 1'b0;
         host_idx_reg <= '0;
         dev_idx_reg  <= '0;
         unmapped_reg <= 1'b0;
      end else begin
         valid_reg    <= valid_next;
         host_idx_reg <= host_idx_next;
         dev_idx_reg  <= dev_idx_next;
         unmapped_reg <= unmapped_next;
      end
   end

   always_comb begin
      sel_rvalid = 1'b0;
      sel_rdata  = '0;
      sel_err    = 1'b0;
      for (int d = 0; d < NrDevices; d++) begin
         if (dev_idx_reg == DevIdxW'(d)) begin
            sel_rvalid = device_rvalid_i[d];
            sel_rdata  = device_rdata_i[d];
            sel_err    = device_err_i[d];
         end
      end
   end

   // Unmapped accesses answer on their own with an error and zero data.
   for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host
      logic resp_here;
      assign resp_here         = valid_reg && (host_idx_reg == HostIdxW'(gi));
      assign host_rvalid_o[gi] = resp_here && (unmapped_reg || sel_rvalid);
      assign host_err_o[gi]    = resp_here && (unmapped_reg || sel_err);
      assign host_rdata_o[gi]  = (resp_here && !unmapped_reg) ? sel_rdata : '0;
   end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect: two hosts, three devices, hand-computed
// expectations for grant, forwarding, response routing, errors and reset.
module tb_bus_interconnect;

   localparam int NH = 2;
   localparam int ND = 3;
   localparam int DW = 32;
   localparam int AW = 32;

   logic                        clk_i = 1'b0;
   logic                        rst_i = 1'b1;
   logic [NH-1:0]               host_req_i;
   logic [NH-1:0]               host_gnt_o;
   logic [NH-1:0][AW-1:0]       host_addr_i;
   logic [NH-1:0]               host_we_i;
   logic [NH-1:0][DW/8-1:0]     host_be_i;
   logic [NH-1:0][DW-1:0]       host_wdata_i;
   logic [NH-1:0]               host_rvalid_o;
   logic [NH-1:0][DW-1:0]       host_rdata_o;
   logic [NH-1:0]               host_err_o;
   logic [ND-1:0]               device_req_o;
   logic [ND-1:0][AW-1:0]       device_addr_o;
   logic [ND-1:0]               device_we_o;
   logic [ND-1:0][DW/8-1:0]     device_be_o;
   logic [ND-1:0][DW-1:0]       device_wdata_o;
   logic [ND-1:0]               device_rvalid_i;
   logic [ND-1:0][DW-1:0]       device_rdata_i;
   logic [ND-1:0]               device_err_i;
   logic [ND-1:0][AW-1:0]       cfg_device_addr_base;
   logic [ND-1:0][AW-1:0]       cfg_device_addr_mask;

   int tests_run    = 0;
   int tests_failed = 0;

   bus_interconnect #(
      .NrDevices    (ND),
      .NrHosts      (NH),
      .DataWidth    (DW),
      .AddressWidth (AW)
   ) dut (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .host_req_i           (host_req_i),
      .host_gnt_o           (host_gnt_o),
      .host_addr_i          (host_addr_i),
      .host_we_i            (host_we_i),
      .host_be_i            (host_be_i),
      .host_wdata_i         (host_wdata_i),
      .host_rvalid_o        (host_rvalid_o),
      .host_rdata_o         (host_rdata_o),
      .host_err_o           (host_err_o),
      .device_req_o         (device_req_o),
      .device_addr_o        (device_addr_o),
      .device_we_o          (device_we_o),
      .device_be_o          (device_be_o),
      .device_wdata_o       (device_wdata_o),
      .device_rvalid_i      (device_rvalid_i),
      .device_rdata_i       (device_rdata_i),
      .device_err_i         (device_err_i),
      .cfg_device_addr_base (cfg_device_addr_base),
      .cfg_device_addr_mask (cfg_device_addr_mask)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic clear_inputs();
      host_req_i      = '0;
      host_addr_i     = '0;
      host_we_i       = '0;
      host_be_i       = '0;
      host_wdata_i    = '0;
      device_rvalid_i = '0;
      device_rdata_i  = '0;
      device_err_i    = '0;
   endtask

   task automatic drive_host(input int h, input logic [AW-1:0] addr, input logic we,
                             input logic [DW/8-1:0] be, input logic [DW-1:0] wdata);
      host_req_i[h]   = 1'b1;
      host_addr_i[h]  = addr;
      host_we_i[h]    = we;
      host_be_i[h]    = be;
      host_wdata_i[h] = wdata;
   endtask

   task automatic dev_resp(input int d, input logic [DW-1:0] rdata, input logic err);
      device_rvalid_i[d] = 1'b1;
      device_rdata_i[d]  = rdata;
      device_err_i[d]    = err;
   endtask

   // Inputs change 1 time unit after the rising edge; checks land 2 units later.
   task automatic next_cycle();
      @(posedge clk_i);
      #1;
      clear_inputs();
   endtask

   initial begin
      cfg_device_addr_base[0] = 32'h0010_0000;
      cfg_device_addr_mask[0] = ~32'h000F_FFFF;
      cfg_device_addr_base[1] = 32'h0002_0000;
      cfg_device_addr_mask[1] = ~32'h0000_03FF;
      cfg_device_addr_base[2] = 32'h0003_0000;
      cfg_device_addr_mask[2] = ~32'h0000_03FF;
      clear_inputs();

      // Reset state, with a stray device response that must be ignored
      @(posedge clk_i);
      #1;
      dev_resp(0, 32'hAAAA_AAAA, 1'b1);
      #2;
      check("reset_rvalid", 64'(host_rvalid_o), 64'h0);
      check("reset_err", 64'(host_err_o), 64'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      clear_inputs();

      // Write to device0
      drive_host(0, 32'h0010_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
      #2;
      check("wr_gnt", 64'(host_gnt_o), 64'h1);
      check("wr_dev_req", 64'(device_req_o), 64'h1);
      check("wr_dev0_addr", 64'(device_addr_o[0]), 64'h0010_0010);
      check("wr_dev0_we", 64'(device_we_o[0]), 64'h1);
      check("wr_dev0_be", 64'(device_be_o[0]), 64'hF);
      check("wr_dev0_wdata", 64'(device_wdata_o[0]), 64'hDEAD_BEEF);
      check("wr_dev1_addr_zero", 64'(device_addr_o[1]), 64'h0);
      next_cycle();
      dev_resp(0, 32'h0, 1'b0);
      #2;
      check("wr_rvalid", 64'(host_rvalid_o), 64'h1);
      check("wr_err", 64'(host_err_o), 64'h0);
      check("idle_gnt", 64'(host_gnt_o), 64'h0);

      // Read from device1; device0 drives distinct rdata that must not leak through
      next_cycle();
      drive_host(0, 32'h0002_0004, 1'b0, 4'hF, 32'h0);
      #2;
      check("rd1_dev_req", 64'(device_req_o), 64'h2);
      check("rd1_dev1_addr", 64'(device_addr_o[1]), 64'h0002_0004);
      check("rd1_dev1_we", 64'(device_we_o[1]), 64'h0);
      next_cycle();
      dev_resp(1, 32'h1234_5678, 1'b0);
      device_rdata_i[0] = 32'hAAAA_5555;
      #2;
      check("rd1_rvalid", 64'(host_rvalid_o), 64'h1);
      check("rd1_rdata", 64'(host_rdata_o[0]), 64'h1234_5678);

      // Unmapped read, with a stray device0 response in the reply cycle
      next_cycle();
      drive_host(0, 32'h0000_0000, 1'b0, 4'hF, 32'h0);
      #2;
      check("unm_gnt", 64'(host_gnt_o), 64'h1);
      check("unm_dev_req", 64'(device_req_o), 64'h0);
      next_cycle();
      dev_resp(0, 32'h0000_0055, 1'b0);
      #2;
      check("unm_rvalid", 64'(host_rvalid_o), 64'h1);
      check("unm_err", 64'(host_err_o), 64'h1);
      check("unm_rdata", 64'(host_rdata_o[0]), 64'h0);

      // Back-to-back reads: device0 then device2
      next_cycle();
      drive_host(0, 32'h0010_0020, 1'b0, 4'hF, 32'h0);
      #2;
      check("b2b_a_dev_req", 64'(device_req_o), 64'h1);
      next_cycle();
      drive_host(0, 32'h0003_0004, 1'b0, 4'hF, 32'h0);
      dev_resp(0, 32'h1111_0000, 1'b0);
      #2;
      check("b2b_b_dev_req", 64'(device_req_o), 64'h4);
      check("b2b_a_rvalid", 64'(host_rvalid_o), 64'h1);
      check("b2b_a_rdata", 64'(host_rdata_o[0]), 64'h1111_0000);
      next_cycle();
      dev_resp(2, 32'h2222_0000, 1'b0);
      device_rdata_i[0] = 32'h9999_9999;
      #2;
      check("b2b_b_rvalid", 64'(host_rvalid_o), 64'h1);
      check("b2b_b_rdata", 64'(host_rdata_o[0]), 64'h2222_0000);

      // Two hosts at once: host0 first, host1 the cycle after
      next_cycle();
      drive_host(0, 32'h0002_0008, 1'b0, 4'hF, 32'h0);
      drive_host(1, 32'h0003_0010, 1'b0, 4'h3, 32'h0);
      #2;
      check("arb_gnt", 64'(host_gnt_o), 64'h1);
      check("arb_dev_req", 64'(device_req_o), 64'h2);
      check("arb_dev1_addr", 64'(device_addr_o[1]), 64'h0002_0008);
      next_cycle();
      drive_host(1, 32'h0003_0010, 1'b0, 4'h3, 32'h0);
      dev_resp(1, 32'h3333_3333, 1'b0);
      #2;
      check("arb_h1_gnt", 64'(host_gnt_o), 64'h2);
      check("arb_h1_dev_req", 64'(device_req_o), 64'h4);
      check("arb_h1_dev2_be", 64'(device_be_o[2]), 64'h3);
      check("arb_h0_rvalid", 64'(host_rvalid_o), 64'h1);
      check("arb_h0_rdata", 64'(host_rdata_o[0]), 64'h3333_3333);
      check("arb_h1_rdata_quiet", 64'(host_rdata_o[1]), 64'h0);
      next_cycle();
      dev_resp(2, 32'h4444_4444, 1'b1);
      #2;
      check("arb_h1_rvalid", 64'(host_rvalid_o), 64'h2);
      check("arb_h1_rdata", 64'(host_rdata_o[1]), 64'h4444_4444);
      check("dev2_err", 64'(host_err_o), 64'h2);
      check("arb_h0_rdata_quiet", 64'(host_rdata_o[0]), 64'h0);

      // Reset with a response pending
      next_cycle();
      drive_host(0, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
      next_cycle();
      dev_resp(0, 32'h5555_5555, 1'b0);
      #2;
      check("pend_rvalid", 64'(host_rvalid_o), 64'h1);
      rst_i = 1'b1;
      #1;
      check("rst_mid_rvalid", 64'(host_rvalid_o), 64'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      dev_resp(0, 32'h6666_6666, 1'b0);
      #2;
      check("post_rst_rvalid", 64'(host_rvalid_o), 64'h0);
      check("post_rst_err", 64'(host_err_o), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
